// File: rtl/ppu_pkg.sv
// Shared PPU definitions: player packet layout, animation codes and packet helpers.
// The game state machine packs each player into one 32-bit word, MSB first.
package ppu_pkg;

    localparam int PKT_W      = 32;
    localparam int POSX_LSB   = 23;
    localparam int POSX_W     = 9;
    localparam int POSY_LSB   = 14;
    localparam int POSY_W     = 9;
    localparam int HEALTH_LSB = 8;
    localparam int HEALTH_W   = 6;
    localparam int LEFT_BIT   = 7;
    localparam int ANIM_LSB   = 3;
    localparam int ANIM_W     = 4;
    localparam int FRAME_LSB  = 1;
    localparam int FRAME_W    = 2;
    localparam int COLOR_BIT  = 0;

    typedef enum logic [3:0] {
        ANIM_IDLE   = 4'd0,
        ANIM_MOVE   = 4'd1,
        ANIM_HIT    = 4'd2,
        ANIM_JUMP   = 4'd3,
        ANIM_LPUNCH = 4'd4,
        ANIM_MPUNCH = 4'd5,
        ANIM_HPUNCH = 4'd6,
        ANIM_DUCK   = 4'd7,
        ANIM_BLKLO  = 4'd8,
        ANIM_BLKHI  = 4'd9
    } anim_e;

    typedef struct packed {
        logic [POSX_W-1:0]   posx;
        logic [POSY_W-1:0]   posy;
        logic [HEALTH_W-1:0] health;
        logic                left;
        logic [ANIM_W-1:0]   animation;
        logic [FRAME_W-1:0]  frame;
        logic                color;
    } player_t;

    function automatic player_t unpack_player(input logic [PKT_W-1:0] pkt);
        player_t p;
        p.posx      = pkt[POSX_LSB +: POSX_W];
        p.posy      = pkt[POSY_LSB +: POSY_W];
        p.health    = pkt[HEALTH_LSB +: HEALTH_W];
        p.left      = pkt[LEFT_BIT];
        p.animation = pkt[ANIM_LSB +: ANIM_W];
        p.frame     = pkt[FRAME_LSB +: FRAME_W];
        p.color     = pkt[COLOR_BIT];
        return p;
    endfunction

    function automatic logic is_attack(input logic [ANIM_W-1:0] anim);
        return (anim == ANIM_LPUNCH) || (anim == ANIM_MPUNCH) || (anim == ANIM_HPUNCH);
    endfunction

endpackage

// File: rtl/sprite_packet_renderer_if.sv
// Pixel/packet bus between the game state machine, the scan timing and the renderer.
interface sprite_packet_renderer_if #(
    parameter int ADDR_W = 19
);
    logic [63:0]       sprites;
    logic              frame_start;
    logic              pix_valid;
    logic [10:0]       hcount;
    logic [10:0]       vcount;
    logic              out_valid;
    logic              spr_hit;
    logic              spr_sel;
    logic [ADDR_W-1:0] rom_addr;
    logic              bar_hit;
    logic              bar_sel;

    modport master (
        output sprites, frame_start, pix_valid, hcount, vcount,
        input  out_valid, spr_hit, spr_sel, rom_addr, bar_hit, bar_sel
    );

    modport slave (
        input  sprites, frame_start, pix_valid, hcount, vcount,
        output out_valid, spr_hit, spr_sel, rom_addr, bar_hit, bar_sel
    );
endinterface

// File: rtl/sprite_window.sv
// Decodes one player packet against the current pixel: window test, sprite row/col,
// ROM attribute bits, clamped health and attack flag.
module sprite_window
    import ppu_pkg::*;
#(
    parameter int SPR_W    = 64,
    parameter int SPR_H    = 64,
    parameter int X_OFFSET = 256,
    parameter int GROUND_Y = 600,
    localparam int ROW_W   = $clog2(SPR_H),
    localparam int COL_W   = $clog2(SPR_W)
) (
    input  logic [PKT_W-1:0] packet_i,
    input  logic [10:0]      h_i,
    input  logic [10:0]      v_i,
    input  logic             flash_i,
    output logic             inside_o,
    output logic [ROW_W-1:0] row_o,
    output logic [COL_W-1:0] col_o,
    output logic [6:0]       attr_o,
    output logic [4:0]       health_o,
    output logic             attack_o
);

    player_t     p;
    logic [11:0] sx;
    logic [11:0] sy;
    logic [11:0] dx;
    logic [11:0] dy;
    logic        in_x;
    logic        in_y;
    logic        hidden;

    assign p  = unpack_player(packet_i);
    assign sx = {3'b000, p.posx} + 12'(X_OFFSET);
    assign sy = 12'(GROUND_Y - SPR_H) - {3'b000, p.posy};
    assign dx = {1'b0, h_i} - sx;
    assign dy = {1'b0, v_i} - sy;

    // Offsets are 12-bit two's complement; a set MSB means the pixel lies before
    // the window, so a window hanging off one screen edge never hits the other.
    assign in_x   = !dx[11] && (dx < 12'(SPR_W));
    assign in_y   = !dy[11] && (dy < 12'(SPR_H));
    assign hidden = (p.animation == ANIM_HIT) && flash_i;

    assign inside_o = in_x && in_y && !hidden;
    assign row_o    = dy[ROW_W-1:0];
    // SPR_W is a power of two, so SPR_W-1-x is the bitwise inverse of x.
    assign col_o    = p.left ? dx[COL_W-1:0] : ~dx[COL_W-1:0];

    assign attr_o   = {p.color, p.animation, p.frame};
    assign health_o = p.health[5] ? 5'd0 : p.health[4:0];
    assign attack_o = is_attack(p.animation);

endmodule

// File: rtl/sprite_packet_renderer.sv
// Per-frame packet shadowing plus a 2-stage pixel pipeline producing sprite hit,
// sprite ROM address and health-bar hit for the palette stage.
module sprite_packet_renderer
    import ppu_pkg::*;
#(
    parameter int SPR_W     = 64,
    parameter int SPR_H     = 64,
    parameter int X_OFFSET  = 256,
    parameter int GROUND_Y  = 600,
    parameter int BAR_Y     = 32,
    parameter int BAR_H     = 8,
    parameter int BAR_X1    = 64,
    parameter int BAR_X2    = 1216,
    parameter int BAR_SCALE = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    sprite_packet_renderer_if.slave   bus
);

    localparam int ROW_W  = $clog2(SPR_H);
    localparam int COL_W  = $clog2(SPR_W);
    localparam int ADDR_W = 7 + ROW_W + COL_W;

    logic [PKT_W-1:0]  shadow1_q;
    logic [PKT_W-1:0]  shadow2_q;
    logic [2:0]        flash_q;

    logic              a_valid_q;
    logic [10:0]       a_h_q;
    logic [10:0]       a_v_q;

    logic              out_valid_q;
    logic              spr_hit_q;
    logic              spr_sel_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic              bar_hit_q;
    logic              bar_sel_q;

    logic              in1, in2;
    logic [ROW_W-1:0]  row1, row2;
    logic [COL_W-1:0]  col1, col2;
    logic [6:0]        attr1, attr2;
    logic [4:0]        health1, health2;
    logic              attack1, attack2;

    logic              spr_hit_d;
    logic              spr_sel_d;
    logic [ADDR_W-1:0] rom_addr_d;
    logic              bar_hit_d;
    logic              bar_sel_d;
    logic              bar_rows;
    logic              bar1, bar2;
    logic [11:0]       hx;
    logic [11:0]       bar1_end;
    logic [11:0]       bar2_start;

    sprite_window #(
        .SPR_W   (SPR_W),
        .SPR_H   (SPR_H),
        .X_OFFSET(X_OFFSET),
        .GROUND_Y(GROUND_Y)
    ) u_win_p1 (
        .packet_i(shadow1_q),
        .h_i     (a_h_q),
        .v_i     (a_v_q),
        .flash_i (flash_q[2]),
        .inside_o(in1),
        .row_o   (row1),
        .col_o   (col1),
        .attr_o  (attr1),
        .health_o(health1),
        .attack_o(attack1)
    );

    sprite_window #(
        .SPR_W   (SPR_W),
        .SPR_H   (SPR_H),
        .X_OFFSET(X_OFFSET),
        .GROUND_Y(GROUND_Y)
    ) u_win_p2 (
        .packet_i(shadow2_q),
        .h_i     (a_h_q),
        .v_i     (a_v_q),
        .flash_i (flash_q[2]),
        .inside_o(in2),
        .row_o   (row2),
        .col_o   (col2),
        .attr_o  (attr2),
        .health_o(health2),
        .attack_o(attack2)
    );

    assign hx         = {1'b0, a_h_q};
    assign bar_rows   = (a_v_q >= 11'(BAR_Y)) && (a_v_q < 11'(BAR_Y + BAR_H));
    assign bar1_end   = 12'(BAR_X1) + ({7'b0, health1} << BAR_SCALE);
    assign bar2_start = 12'(BAR_X2) - ({7'b0, health2} << BAR_SCALE);
    assign bar1       = bar_rows && (hx >= 12'(BAR_X1)) && (hx < bar1_end);
    assign bar2       = bar_rows && (hx >= bar2_start) && (hx < 12'(BAR_X2));

    always_comb begin
        spr_hit_d  = in1 || in2;
        // An attacking P2 is drawn over a non-attacking P1; every other overlap keeps P1 on top.
        spr_sel_d  = in2 && (!in1 || (attack2 && !attack1));
        rom_addr_d = spr_sel_d ? {attr2, row2, col2} : {attr1, row1, col1};
        bar_hit_d  = bar1 || bar2;
        bar_sel_d  = !bar1 && bar2;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow1_q <= '0;
            shadow2_q <= '0;
            flash_q   <= '0;
        end else if (bus.frame_start) begin
            shadow1_q <= bus.sprites[63:32];
            shadow2_q <= bus.sprites[31:0];
            flash_q   <= flash_q + 3'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_valid_q <= 1'b0;
            a_h_q     <= '0;
            a_v_q     <= '0;
        end else begin
            a_valid_q <= bus.pix_valid;
            a_h_q     <= bus.hcount;
            a_v_q     <= bus.vcount;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            spr_hit_q   <= 1'b0;
            spr_sel_q   <= 1'b0;
            rom_addr_q  <= '0;
            bar_hit_q   <= 1'b0;
            bar_sel_q   <= 1'b0;
        end else begin
            out_valid_q <= a_valid_q;
            if (a_valid_q) begin
                spr_hit_q  <= spr_hit_d;
                spr_sel_q  <= spr_sel_d;
                rom_addr_q <= rom_addr_d;
                bar_hit_q  <= bar_hit_d;
                bar_sel_q  <= bar_sel_d;
            end else begin
                spr_hit_q  <= 1'b0;
                bar_hit_q  <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.spr_hit   = spr_hit_q;
    assign bus.spr_sel   = spr_sel_q;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.bar_hit   = bar_hit_q;
    assign bus.bar_sel   = bar_sel_q;

endmodule

// File: tb/tb_sprite_packet_renderer.sv
// Directed bench for sprite_packet_renderer with hand-computed expectations.
module tb_sprite_packet_renderer;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [2:0] flash_cnt;

    sprite_packet_renderer_if #(.ADDR_W(19)) bus ();

    sprite_packet_renderer dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] pkt(input int px, input int py, input int hl,
                                        input int lf, input int an, input int fr, input int co);
        return {9'(px), 9'(py), 6'(hl), 1'(lf), 4'(an), 2'(fr), 1'(co)};
    endfunction

    task automatic load(input logic [31:0] p1, input logic [31:0] p2);
        @(negedge clock);
        bus.sprites     = {p1, p2};
        bus.frame_start = 1'b1;
        @(negedge clock);
        bus.frame_start = 1'b0;
        flash_cnt       = flash_cnt + 3'd1;
    endtask

    // Drives one pixel and returns once its result is on the outputs.
    task automatic scan(input int h, input int v);
        @(negedge clock);
        bus.pix_valid = 1'b1;
        bus.hcount    = 11'(h);
        bus.vcount    = 11'(v);
        @(negedge clock);
        bus.pix_valid = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.spr_hit !== 1'b0 || bus.bar_hit !== 1'b0) begin n_fail++; $display("FAIL rst_hits: got spr=%b bar=%b want 0 0", bus.spr_hit, bus.bar_hit); end
        n_checks++; if (bus.rom_addr !== 19'd0 || bus.spr_sel !== 1'b0 || bus.bar_sel !== 1'b0) begin n_fail++; $display("FAIL rst_addr_sel: got addr=%h ssel=%b bsel=%b want 0", bus.rom_addr, bus.spr_sel, bus.bar_sel); end
        @(negedge clock);
        reset = 1'b0;
        load(pkt(0, 0, 0, 1, 1, 2, 0), pkt(400, 0, 0, 1, 0, 0, 0));
        @(negedge clock);
        bus.pix_valid = 1'b1; bus.hcount = 11'd256; bus.vcount = 11'd536;
        @(posedge clock); #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early: got out_valid=%b want 0", bus.out_valid); end
        @(negedge clock);
        bus.pix_valid = 1'b0;
        @(posedge clock); #1;
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL latency_2: got out_valid=%b want 1", bus.out_valid); end
        n_checks++; if (bus.spr_hit !== 1'b1 || bus.spr_sel !== 1'b0) begin n_fail++; $display("FAIL p1_corner_hit: got hit=%b sel=%b want 1 0", bus.spr_hit, bus.spr_sel); end
        n_checks++; if (bus.rom_addr !== {1'b0, 4'd1, 2'd2, 6'd0, 6'd0}) begin n_fail++; $display("FAIL p1_corner_addr: got %h want %h", bus.rom_addr, {1'b0, 4'd1, 2'd2, 6'd0, 6'd0}); end
        @(posedge clock); #1;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.spr_hit !== 1'b0) begin n_fail++; $display("FAIL idle_clears: got valid=%b hit=%b want 0 0", bus.out_valid, bus.spr_hit); end
        n_checks++; if (bus.rom_addr !== {1'b0, 4'd1, 2'd2, 6'd0, 6'd0}) begin n_fail++; $display("FAIL idle_holds_addr: got %h", bus.rom_addr); end
        scan(255, 536);
        n_checks++; if (bus.out_valid !== 1'b1 || bus.spr_hit !== 1'b0) begin n_fail++; $display("FAIL left_of_window: got valid=%b hit=%b want 1 0", bus.out_valid, bus.spr_hit); end
    endtask

    task automatic test_mirroring();
        load(pkt(0, 0, 0, 0, 1, 2, 0), pkt(400, 0, 0, 1, 0, 0, 0));
        scan(256, 536);
        n_checks++; if (bus.spr_hit !== 1'b1 || bus.rom_addr !== {1'b0, 4'd1, 2'd2, 6'd0, 6'd63}) begin n_fail++; $display("FAIL mirror_left_edge: got hit=%b addr=%h", bus.spr_hit, bus.rom_addr); end
        scan(319, 536);
        n_checks++; if (bus.spr_hit !== 1'b1 || bus.rom_addr !== {1'b0, 4'd1, 2'd2, 6'd0, 6'd0}) begin n_fail++; $display("FAIL mirror_right_edge: got hit=%b addr=%h", bus.spr_hit, bus.rom_addr); end
        scan(320, 536);
        n_checks++; if (bus.spr_hit !== 1'b0) begin n_fail++; $display("FAIL mirror_past_right: got hit=%b want 0", bus.spr_hit); end
        scan(300, 599);
        n_checks++; if (bus.spr_hit !== 1'b1 || bus.rom_addr !== {1'b0, 4'd1, 2'd2, 6'd63, 6'd19}) begin n_fail++; $display("FAIL bottom_row: got hit=%b addr=%h", bus.spr_hit, bus.rom_addr); end
        scan(300, 600);
        n_checks++; if (bus.spr_hit !== 1'b0) begin n_fail++; $display("FAIL below_feet: got hit=%b want 0", bus.spr_hit); end
        scan(300, 535);
        n_checks++; if (bus.spr_hit !== 1'b0) begin n_fail++; $display("FAIL above_head: got hit=%b want 0", bus.spr_hit); end
    endtask

    task automatic test_tearing();
        load(pkt(0, 0, 0, 1, 1, 2, 0), pkt(400, 0, 0, 1, 0, 0, 0));
        @(negedge clock);
        bus.sprites = {pkt(100, 0, 0, 1, 1, 2, 0), pkt(400, 0, 0, 1, 0, 0, 0)};
        scan(256, 536);
        n_checks++; if (bus.spr_hit !== 1'b1 || bus.rom_addr !== {1'b0, 4'd1, 2'd2, 6'd0, 6'd0}) begin n_fail++; $display("FAIL no_tear: got hit=%b addr=%h", bus.spr_hit, bus.rom_addr); end
        load(pkt(100, 0, 0, 1, 1, 2, 0), pkt(400, 0, 0, 1, 0, 0, 0));
        scan(256, 536);
        n_checks++; if (bus.spr_hit !== 1'b0) begin n_fail++; $display("FAIL old_pos_gone: got hit=%b want 0", bus.spr_hit); end
        scan(356, 536);
        n_checks++; if (bus.spr_hit !== 1'b1 || bus.rom_addr !== {1'b0, 4'd1, 2'd2, 6'd0, 6'd0}) begin n_fail++; $display("FAIL new_pos_used: got hit=%b addr=%h", bus.spr_hit, bus.rom_addr); end
    endtask

    task automatic test_priority();
        load(pkt(0, 0, 0, 1, 1, 0, 0), pkt(10, 0, 0, 1, 6, 3, 1));
        scan(300, 540);
        n_checks++; if (bus.spr_hit !== 1'b1 || bus.spr_sel !== 1'b1) begin n_fail++; $display("FAIL p2_attack_wins: got hit=%b sel=%b want 1 1", bus.spr_hit, bus.spr_sel); end
        n_checks++; if (bus.rom_addr !== {1'b1, 4'd6, 2'd3, 6'd4, 6'd34}) begin n_fail++; $display("FAIL p2_attack_addr: got %h want %h", bus.rom_addr, {1'b1, 4'd6, 2'd3, 6'd4, 6'd34}); end
        scan(325, 540);
        n_checks++; if (bus.spr_hit !== 1'b1 || bus.spr_sel !== 1'b1 || bus.rom_addr !== {1'b1, 4'd6, 2'd3, 6'd4, 6'd59}) begin n_fail++; $display("FAIL p2_only: got hit=%b sel=%b addr=%h", bus.spr_hit, bus.spr_sel, bus.rom_addr); end
        load(pkt(0, 0, 0, 1, 5, 0, 0), pkt(10, 0, 0, 1, 6, 3, 1));
        scan(300, 540);
        n_checks++; if (bus.spr_hit !== 1'b1 || bus.spr_sel !== 1'b0) begin n_fail++; $display("FAIL both_attack_p1: got hit=%b sel=%b want 1 0", bus.spr_hit, bus.spr_sel); end
        n_checks++; if (bus.rom_addr !== {1'b0, 4'd5, 2'd0, 6'd4, 6'd44}) begin n_fail++; $display("FAIL both_attack_addr: got %h want %h", bus.rom_addr, {1'b0, 4'd5, 2'd0, 6'd4, 6'd44}); end
    endtask

    task automatic test_health_bars();
        load(pkt(0, 0, 31, 1, 0, 0, 0), pkt(400, 0, 0, 1, 0, 0, 0));
        scan(64, 32);
        n_checks++; if (bus.bar_hit !== 1'b1 || bus.bar_sel !== 1'b0 || bus.spr_hit !== 1'b0) begin n_fail++; $display("FAIL bar1_start: got bar=%b sel=%b spr=%b want 1 0 0", bus.bar_hit, bus.bar_sel, bus.spr_hit); end
        scan(311, 32);
        n_checks++; if (bus.bar_hit !== 1'b1) begin n_fail++; $display("FAIL bar1_last: got %b want 1", bus.bar_hit); end
        scan(312, 32);
        n_checks++; if (bus.bar_hit !== 1'b0) begin n_fail++; $display("FAIL bar1_end: got %b want 0", bus.bar_hit); end
        scan(63, 32);
        n_checks++; if (bus.bar_hit !== 1'b0) begin n_fail++; $display("FAIL bar1_before: got %b want 0", bus.bar_hit); end
        scan(100, 39);
        n_checks++; if (bus.bar_hit !== 1'b1) begin n_fail++; $display("FAIL bar_last_row: got %b want 1", bus.bar_hit); end
        scan(100, 40);
        n_checks++; if (bus.bar_hit !== 1'b0) begin n_fail++; $display("FAIL bar_below: got %b want 0", bus.bar_hit); end
        scan(100, 31);
        n_checks++; if (bus.bar_hit !== 1'b0) begin n_fail++; $display("FAIL bar_above: got %b want 0", bus.bar_hit); end
        scan(1215, 32);
        n_checks++; if (bus.bar_hit !== 1'b0) begin n_fail++; $display("FAIL bar2_empty: got %b want 0", bus.bar_hit); end
        load(pkt(0, 0, 6'b110111, 1, 0, 0, 0), pkt(400, 0, 1, 1, 0, 0, 0));
        scan(64, 32);
        n_checks++; if (bus.bar_hit !== 1'b0) begin n_fail++; $display("FAIL bar1_underflow: got %b want 0", bus.bar_hit); end
        scan(1208, 32);
        n_checks++; if (bus.bar_hit !== 1'b1 || bus.bar_sel !== 1'b1) begin n_fail++; $display("FAIL bar2_start: got bar=%b sel=%b want 1 1", bus.bar_hit, bus.bar_sel); end
        scan(1215, 32);
        n_checks++; if (bus.bar_hit !== 1'b1 || bus.bar_sel !== 1'b1) begin n_fail++; $display("FAIL bar2_last: got bar=%b sel=%b want 1 1", bus.bar_hit, bus.bar_sel); end
        scan(1207, 32);
        n_checks++; if (bus.bar_hit !== 1'b0) begin n_fail++; $display("FAIL bar2_before: got %b want 0", bus.bar_hit); end
        scan(1216, 32);
        n_checks++; if (bus.bar_hit !== 1'b0) begin n_fail++; $display("FAIL bar2_end: got %b want 0", bus.bar_hit); end
    endtask

    task automatic test_hit_flash();
        logic want;
        for (int f = 0; f < 8; f++) begin
            load(pkt(0, 0, 0, 1, 2, 0, 0), pkt(400, 0, 0, 1, 0, 0, 0));
            want = ~flash_cnt[2];
            scan(256, 536);
            n_checks++; if (bus.spr_hit !== want) begin n_fail++; $display("FAIL flash_in cnt=%0d: got %b want %b", flash_cnt, bus.spr_hit, want); end
            scan(200, 536);
            n_checks++; if (bus.spr_hit !== 1'b0) begin n_fail++; $display("FAIL flash_out cnt=%0d: got %b want 0", flash_cnt, bus.spr_hit); end
        end
    endtask

    task automatic test_back_to_back();
        logic       want_hit;
        logic [5:0] want_col;
        load(pkt(0, 0, 0, 1, 1, 2, 0), pkt(400, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i <= 5; i++) begin
            @(negedge clock);
            if (i < 5) begin
                bus.pix_valid = 1'b1; bus.hcount = 11'(254 + i); bus.vcount = 11'd536;
            end else begin
                bus.pix_valid = 1'b0;
            end
            @(posedge clock); #1;
            if (i >= 1) begin
                want_hit = (i >= 3);
                want_col = 6'(i - 3);
                n_checks++; if (bus.out_valid !== 1'b1 || bus.spr_hit !== want_hit) begin n_fail++; $display("FAIL b2b_hit px=%0d: got valid=%b hit=%b want 1 %b", i - 1, bus.out_valid, bus.spr_hit, want_hit); end
                if (want_hit) begin
                    n_checks++; if (bus.rom_addr !== {1'b0, 4'd1, 2'd2, 6'd0, want_col}) begin n_fail++; $display("FAIL b2b_addr px=%0d: got %h want %h", i - 1, bus.rom_addr, {1'b0, 4'd1, 2'd2, 6'd0, want_col}); end
                end
            end
        end
    endtask

    task automatic test_reset_midline();
        load(pkt(0, 0, 0, 1, 1, 2, 0), pkt(400, 0, 0, 1, 0, 0, 0));
        @(negedge clock);
        bus.pix_valid = 1'b1; bus.hcount = 11'd256; bus.vcount = 11'd536;
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.spr_hit !== 1'b0) begin n_fail++; $display("FAIL midline_flush: got valid=%b hit=%b want 0 0", bus.out_valid, bus.spr_hit); end
        @(negedge clock);
        reset = 1'b0; bus.pix_valid = 1'b0; flash_cnt = 3'd0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midline_no_ghost: got valid=%b want 0", bus.out_valid); end
        scan(256, 536);
        n_checks++; if (bus.out_valid !== 1'b1 || bus.spr_hit !== 1'b1 || bus.spr_sel !== 1'b0) begin n_fail++; $display("FAIL zero_shadow_hit: got valid=%b hit=%b sel=%b want 1 1 0", bus.out_valid, bus.spr_hit, bus.spr_sel); end
        n_checks++; if (bus.rom_addr !== {1'b0, 4'd0, 2'd0, 6'd0, 6'd63}) begin n_fail++; $display("FAIL zero_shadow_addr: got %h want %h", bus.rom_addr, {1'b0, 4'd0, 2'd0, 6'd0, 6'd63}); end
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        flash_cnt       = 3'd0;
        reset           = 1'b1;
        bus.sprites     = '0;
        bus.frame_start = 1'b0;
        bus.pix_valid   = 1'b0;
        bus.hcount      = '0;
        bus.vcount      = '0;
        repeat (3) @(posedge clock);
        test_reset();
        test_mirroring();
        test_tearing();
        test_priority();
        test_health_bars();
        test_hit_flash();
        test_back_to_back();
        test_reset_midline();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
